// File: rtl/rr_arb_oht_if.sv
// Grant handshake bundle between the round-robin arbiter and its consumer.
// The arbiter side (master) presents the one-hot grant and its binary index;
// the consumer side (slave) drives the request lines and the ready strobe.
interface rr_arb_oht_if #(
    parameter int WIDTH = 16
) ();
    localparam int WIDTH_LOG = $clog2(WIDTH);

    logic [WIDTH-1:0]     req;
    logic                 gnt_vld;
    logic                 gnt_rdy;
    logic [WIDTH-1:0]     gnt_oht;
    logic [WIDTH_LOG-1:0] gnt_bin;
    logic [WIDTH_LOG-1:0] ptr;

    modport master (
        input  req,
        input  gnt_rdy,
        output gnt_vld,
        output gnt_oht,
        output gnt_bin,
        output ptr
    );

    modport slave (
        output req,
        output gnt_rdy,
        input  gnt_vld,
        input  gnt_oht,
        input  gnt_bin,
        input  ptr
    );
endinterface

// File: rtl/rr_arb_oht.sv
// Registered round-robin arbiter with a sticky one-hot grant held under a
// valid/ready handshake. The binary grant index comes combinationally from the
// grant register through an internal one-hot-to-binary encoder, so it adds no
// latency. The start pointer moves to one past the granted index only when a
// grant is actually transferred.
module rr_arb_oht #(
    parameter int WIDTH          = 16,
    parameter int SPLIT          = 4,
    parameter int IMPLEMENTATION = 0
) (
    input  logic          clk,
    input  logic          rst,
    rr_arb_oht_if.master  arb_if
);
    localparam int WIDTH_LOG = $clog2(WIDTH);
    localparam int NGRP      = (WIDTH + SPLIT - 1) / SPLIT;
    localparam logic [WIDTH_LOG-1:0] LAST_IDX = WIDTH_LOG'(WIDTH - 1);

    logic [WIDTH-1:0]     gnt_q;
    logic [WIDTH-1:0]     gnt_d;
    logic                 vld_q;
    logic                 vld_d;
    logic [WIDTH_LOG-1:0] ptr_q;
    logic [WIDTH_LOG-1:0] ptr_d;
    logic [WIDTH_LOG-1:0] ptr_inc_s;
    logic [WIDTH_LOG-1:0] ptr_sel_s;
    logic [WIDTH_LOG-1:0] gnt_bin_s;
    logic                 xfer_s;
    logic [WIDTH-1:0]     mask_s;
    logic [WIDTH-1:0]     masked_s;
    logic [WIDTH-1:0]     pick_s;

    // One-hot to binary encoder on the grant register (the oht2bin stage).
    generate
        if (IMPLEMENTATION == 0) begin : u_oht2bin
            logic [WIDTH_LOG-1:0] grp_bin_s [NGRP];

            // Split tree: OR the indices inside each SPLIT-wide group, then across groups.
            always_comb begin
                for (int g = 0; g < NGRP; g++) begin
                    grp_bin_s[g] = '0;
                end
                for (int i = 0; i < WIDTH; i++) begin
                    if (gnt_q[i]) begin
                        grp_bin_s[i / SPLIT] = grp_bin_s[i / SPLIT] | WIDTH_LOG'(i);
                    end else begin
                        grp_bin_s[i / SPLIT] = grp_bin_s[i / SPLIT];
                    end
                end
                gnt_bin_s = '0;
                for (int g = 0; g < NGRP; g++) begin
                    gnt_bin_s = gnt_bin_s | grp_bin_s[g];
                end
            end
        end else begin : u_oht2bin
            // Flat encoder: each index bit is the OR of the grant lines whose index has it set.
            always_comb begin
                gnt_bin_s = '0;
                for (int i = 0; i < WIDTH; i++) begin
                    if (gnt_q[i]) begin
                        gnt_bin_s = gnt_bin_s | WIDTH_LOG'(i);
                    end else begin
                        gnt_bin_s = gnt_bin_s;
                    end
                end
            end
        end
    endgenerate

    // Transfer detection and pointer advance; arbitration uses the advanced pointer on a transfer.
    always_comb begin
        xfer_s = vld_q & arb_if.gnt_rdy;
        if (gnt_bin_s == LAST_IDX) begin
            ptr_inc_s = '0;
        end else begin
            ptr_inc_s = gnt_bin_s + WIDTH_LOG'(1);
        end
        if (xfer_s) begin
            ptr_sel_s = ptr_inc_s;
            ptr_d     = ptr_inc_s;
        end else begin
            ptr_sel_s = ptr_q;
            ptr_d     = ptr_q;
        end
    end

    // Masked priority pick from the pointer upward, falling back to an unmasked pick to wrap.
    always_comb begin
        for (int i = 0; i < WIDTH; i++) begin
            mask_s[i] = (i >= int'(ptr_sel_s));
        end
        masked_s = arb_if.req & mask_s;
        if (|masked_s) begin
            pick_s = masked_s & (~masked_s + WIDTH'(1));
        end else begin
            pick_s = arb_if.req & (~arb_if.req + WIDTH'(1));
        end
    end

    // Grant is sticky until transferred; otherwise load the fresh arbitration result.
    always_comb begin
        if (vld_q && !arb_if.gnt_rdy) begin
            gnt_d = gnt_q;
        end else begin
            gnt_d = pick_s;
        end
        vld_d = |gnt_d;
    end

    // State registers: grant vector, its valid flag and the round-robin pointer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gnt_q <= '0;
            vld_q <= 1'b0;
            ptr_q <= '0;
        end else begin
            gnt_q <= gnt_d;
            vld_q <= vld_d;
            ptr_q <= ptr_d;
        end
    end

    assign arb_if.gnt_vld = vld_q;
    assign arb_if.gnt_oht = gnt_q;
    assign arb_if.gnt_bin = gnt_bin_s;
    assign arb_if.ptr     = ptr_q;
endmodule

// File: tb/tb_rr_arb_oht.sv
// Self-checking bench for rr_arb_oht: directed scenarios followed by random
// request/ready traffic, all compared against an index-level round-robin model.
module tb_rr_arb_oht;
    localparam int W = 16;

    logic clk;
    logic rst;
    int   total;
    int   bad;
    int   m_ptr;
    int   m_gnt;

    rr_arb_oht_if #(.WIDTH(W)) bus ();

    rr_arb_oht #(.WIDTH(W), .SPLIT(4), .IMPLEMENTATION(0)) dut (
        .clk    (clk),
        .rst    (rst),
        .arb_if (bus.master)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic int arb(input logic [W-1:0] r, input int p);
        for (int j = 0; j < W; j++) begin
            if (r[(p + j) % W]) return (p + j) % W;
        end
        return -1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        logic [31:0] exp_oht;
        exp_oht = (m_gnt >= 0) ? (32'd1 << m_gnt) : 32'd0;
        chk({tag, "_vld"}, 32'(bus.gnt_vld), (m_gnt >= 0) ? 32'd1 : 32'd0);
        chk({tag, "_oht"}, 32'(bus.gnt_oht), exp_oht);
        chk({tag, "_bin"}, 32'(bus.gnt_bin), (m_gnt >= 0) ? 32'(m_gnt) : 32'd0);
        chk({tag, "_ptr"}, 32'(bus.ptr), 32'(m_ptr));
    endtask

    // Apply one cycle of stimulus, advance the model, and compare on the following negedge.
    task automatic step(input string tag, input logic [W-1:0] r, input logic rdy);
        bus.req     = r;
        bus.gnt_rdy = rdy;
        if (!(m_gnt >= 0 && !rdy)) begin
            if (m_gnt >= 0) m_ptr = (m_gnt + 1) % W;
            m_gnt = arb(r, m_ptr);
        end
        @(posedge clk);
        @(negedge clk);
        check_all(tag);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        m_ptr = 0;
        m_gnt = -1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        logic [W-1:0] rr;
        logic         rd;
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        bus.req     = '0;
        bus.gnt_rdy = 1'b0;
        m_ptr = 0;
        m_gnt = -1;

        // 1: reset then idle
        do_reset();
        check_all("t1_rst");
        for (int i = 0; i < 5; i++) step("t1_idle", 16'h0000, 1'b0);

        // 2: single request, granted every cycle
        step("t2", 16'h0020, 1'b1);
        chk("t2_first_bin", 32'(bus.gnt_bin), 32'd5);
        chk("t2_first_oht", 32'(bus.gnt_oht), 32'h0020);
        step("t2", 16'h0020, 1'b1);
        chk("t2_ptr6", 32'(bus.ptr), 32'd6);
        chk("t2_again_vld", 32'(bus.gnt_vld), 32'd1);

        // 3: full rotation with wrap
        do_reset();
        for (int i = 0; i < 18; i++) begin
            step("t3", 16'hFFFF, 1'b1);
            chk("t3_seq_bin", 32'(bus.gnt_bin), 32'(i % 16));
            if (i == 16) chk("t3_wrap_ptr", 32'(bus.ptr), 32'd0);
        end
        step("t3_drain", 16'h0000, 1'b1);

        // 4: backpressure holds the grant despite request changes
        do_reset();
        step("t4", 16'h8001, 1'b0);
        chk("t4_first_oht", 32'(bus.gnt_oht), 32'h0001);
        step("t4_hold", 16'h8000, 1'b0);
        step("t4_hold", 16'hFFFE, 1'b0);
        step("t4_hold", 16'h0000, 1'b0);
        chk("t4_hold_oht", 32'(bus.gnt_oht), 32'h0001);
        step("t4", 16'h8001, 1'b1);
        chk("t4_next_oht", 32'(bus.gnt_oht), 32'h8000);
        chk("t4_next_bin", 32'(bus.gnt_bin), 32'd15);
        step("t4", 16'h8001, 1'b1);
        chk("t4_back_oht", 32'(bus.gnt_oht), 32'h0001);
        step("t4_drain", 16'h0000, 1'b1);

        // 5: fairness with skip from ptr=3
        step("t5_seed", 16'h0004, 1'b1);
        step("t5", 16'h0106, 1'b1);
        chk("t5_ptr3", 32'(bus.ptr), 32'd3);
        chk("t5_g0", 32'(bus.gnt_bin), 32'd8);
        step("t5", 16'h0106, 1'b1);
        chk("t5_g1", 32'(bus.gnt_bin), 32'd1);
        step("t5", 16'h0106, 1'b1);
        chk("t5_g2", 32'(bus.gnt_bin), 32'd2);
        step("t5", 16'h0106, 1'b1);
        chk("t5_g3", 32'(bus.gnt_bin), 32'd8);
        step("t5_drain", 16'h0000, 1'b1);

        // 6: asynchronous reset mid-grant
        step("t6", 16'h0080, 1'b0);
        chk("t6_pre_bin", 32'(bus.gnt_bin), 32'd7);
        #2 rst = 1'b1;
        #1;
        m_ptr = 0;
        m_gnt = -1;
        chk("t6_async_vld", 32'(bus.gnt_vld), 32'd0);
        chk("t6_async_ptr", 32'(bus.ptr), 32'd0);
        chk("t6_async_oht", 32'(bus.gnt_oht), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        step("t6_post", 16'h0080, 1'b1);
        chk("t6_post_bin", 32'(bus.gnt_bin), 32'd7);

        // 7: random traffic against the model
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 4) == 0) rr = '0;
            else rr = W'($urandom) & W'($urandom);
            rd = ($urandom_range(0, 3) != 0);
            step("rnd", rr, rd);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/rr_arb_oht.md
Name: rr_arb_oht

Overview:
- Registered round-robin arbiter.
- Takes a vector of request lines and issues one grant at a time as a one-hot vector. It also outputs the binary index of the grant, produced by an internal oht2bin instance.
- Sits directly upstream of oht2bin-style consumers: its one-hot grant is the oht input that stage expects.
- The grant is held under a valid/ready handshake until the downstream consumer accepts it.

Parameters:
- WIDTH, 16, number of requesters (any value ≥ 2, not required to be a power of 2).
- SPLIT, 4, tree split factor passed to the internal oht2bin.
- IMPLEMENTATION, 0, implementation selector passed to the internal oht2bin.
- WIDTH_LOG, $clog2(WIDTH), localparam, index width.

Ports:
- clk  input  1  clock, all state on rising edge.
- rst  input  1  reset, asynchronous, active-high.
- req  input  WIDTH  request vector; bit i = requester i.
- gnt_vld  output  1  a grant is presented.
- gnt_rdy  input  1  downstream accepts the grant; transfer = gnt_vld & gnt_rdy.
- gnt_oht  output  WIDTH  one-hot grant; all zeros when gnt_vld=0.
- gnt_bin  output  WIDTH_LOG  binary index of gnt_oht, from oht2bin; 0 when gnt_vld=0.
- ptr  output  WIDTH_LOG  current round-robin start pointer (for debug and checking).

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - gnt_vld=0, gnt_oht='0, gnt_bin=0, ptr=0.
  - Reset asserted mid-grant discards the grant immediately. No pointer update.
- State: IDLE (gnt_vld=0) and GRANT (gnt_vld=1); the registered gnt_oht is the state.
- Arbitration function:
  - Selects the first set bit of req, searching from index ptr upward, wrapping from WIDTH-1 to 0.
  - Implemented as a masked priority pass (req & mask[ptr]) with fallback to an unmasked pass when the masked result is empty.
- Transitions:
  - IDLE and |req: next edge loads the arbitration result; go to GRANT. Latency is 1 cycle from req to gnt_vld.
  - IDLE and req=0: stay in IDLE.
  - GRANT and no transfer: grant is held unchanged (sticky), even if req drops or higher-priority requests appear.
  - GRANT and transfer at index k:
    - ptr ← (k+1) mod WIDTH on the same edge. For non-power-of-2 WIDTH, k=WIDTH-1 gives ptr=0.
    - The grant register loads the arbitration result computed from the same-cycle req using the updated pointer ((k+1) mod WIDTH).
    - If req is zero, return to IDLE.
    - Back-to-back grants are therefore possible every cycle while gnt_rdy=1.
- ptr changes only on transfer.
- Requester k is granted again only after every other active requester has been served once (fairness bound: at most WIDTH-1 transfers between successive grants to a continuously requesting line).
- Invariants, every cycle: gnt_oht is one-hot or zero; gnt_vld == |gnt_oht; gnt_bin == index of gnt_oht.
- gnt_bin comes combinationally from the gnt_oht register through oht2bin, so it adds no cycle of latency.
- gnt_rdy while gnt_vld=0 is ignored.
- All ports have defined values; X on req after reset must not propagate into ptr.

Test Plan:
1. Reset, then idle: rst pulse, req=0 for 5 cycles -> gnt_vld=0, gnt_oht=16'h0000, gnt_bin=0, ptr=0 throughout.
2. Single request:
   - Stimulus: req=16'h0020 from cycle 1, gnt_rdy=1.
   - Required: gnt_vld=1 from cycle 2 with gnt_oht=16'h0020 and gnt_bin=5.
   - Required: a grant on every following cycle, with ptr=6 after the first transfer.
3. Full rotation with wrap:
   - Stimulus: req=16'hFFFF held, gnt_rdy=1.
   - Required: gnt_bin sequence 0,1,...,15,0,1 on consecutive cycles.
   - Required: ptr after the index-15 transfer equals 0.
4. Backpressure:
   - Stimulus: req=16'h8001, gnt_rdy=0 for 4 cycles, then 1.
   - Required: gnt_oht stays 16'h0001 for 4 cycles despite req changes.
   - Required: after the transfer, the next grant is 16'h8000 (bin 15), then 16'h0001.
5. Fairness with skip:
   - Stimulus: ptr=3 (reached by serving index 2), req=16'h0106, gnt_rdy=1.
   - Required: grants in order bin 8, 1, 2, 8.
6. Reset mid-operation:
   - Stimulus: gnt_vld=1 with gnt_bin=7; assert rst asynchronously between clock edges.
   - Required: gnt_vld=0 and ptr=0 immediately, before the next edge.
   - Required: after release with req=16'h0080, the first grant is bin 7 one cycle later.
